// File: rtl/demux_fifo1x2_conductual.sv
// Routes valid words from the upstream 2x1 mux into one of two independent lane FIFOs,
// each drained by its own pop strobe; overflow and underflow are flagged sticky.

module demux_fifo1x2_lane #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  pop_ok;
  logic                  push_ok;

  // A push into a full lane is still accepted when a pop frees the head slot on the same edge.
  always_comb begin
    pop_ok  = pop & (count != '0);
    push_ok = push & ((count != DEPTH_C) | pop);
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    empty = (count == '0);
    full  = (count == DEPTH_C);
  end

endmodule

module demux_fifo1x2_conductual #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  demux_sel,
  input  logic                  pop0,
  input  logic                  pop1,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  valid_out0,
  output logic                  valid_out1,
  output logic                  empty0,
  output logic                  empty1,
  output logic                  full0,
  output logic                  full1,
  output logic                  overflow0,
  output logic                  overflow1,
  output logic                  underflow0,
  output logic                  underflow1
);

  logic push0;
  logic push1;

  always_comb begin
    push0 = valid_in & ~demux_sel;
    push1 = valid_in & demux_sel;
  end

  demux_fifo1x2_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .pop       (pop0),
    .data_in   (data_in),
    .data_out  (data_out0),
    .valid_out (valid_out0),
    .empty     (empty0),
    .full      (full0),
    .overflow  (overflow0),
    .underflow (underflow0)
  );

  demux_fifo1x2_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .pop       (pop1),
    .data_in   (data_in),
    .data_out  (data_out1),
    .valid_out (valid_out1),
    .empty     (empty1),
    .full      (full1),
    .overflow  (overflow1),
    .underflow (underflow1)
  );

endmodule

// File: tb/tb_demux_fifo1x2_conductual.sv
// Directed bench for the two-lane demux FIFO; a per-lane queue scoreboard predicts every output.

module tb_demux_fifo1x2_conductual;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [1:0] data_in;
  logic       demux_sel;
  logic       pop0;
  logic       pop1;
  logic [1:0] data_out0;
  logic [1:0] data_out1;
  logic       valid_out0;
  logic       valid_out1;
  logic       empty0;
  logic       empty1;
  logic       full0;
  logic       full1;
  logic       overflow0;
  logic       overflow1;
  logic       underflow0;
  logic       underflow1;

  demux_fifo1x2_conductual #(
    .DATA_WIDTH (2),
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .demux_sel  (demux_sel),
    .pop0       (pop0),
    .pop1       (pop1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .empty0     (empty0),
    .empty1     (empty1),
    .full0      (full0),
    .full1      (full1),
    .overflow0  (overflow0),
    .overflow1  (overflow1),
    .underflow0 (underflow0),
    .underflow1 (underflow1)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] m_data0, m_data1;
  logic       m_valid0, m_valid1;
  logic       m_ovf0, m_ovf1, m_unf0, m_unf1;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, " valid_out0"}, {1'b0, valid_out0}, {1'b0, m_valid0});
    check({step, " valid_out1"}, {1'b0, valid_out1}, {1'b0, m_valid1});
    check({step, " data_out0"},  data_out0, m_data0);
    check({step, " data_out1"},  data_out1, m_data1);
    check({step, " empty0"},     {1'b0, empty0}, {1'b0, q0.size() == 0});
    check({step, " empty1"},     {1'b0, empty1}, {1'b0, q1.size() == 0});
    check({step, " full0"},      {1'b0, full0},  {1'b0, q0.size() == 4});
    check({step, " full1"},      {1'b0, full1},  {1'b0, q1.size() == 4});
    check({step, " overflow0"},  {1'b0, overflow0},  {1'b0, m_ovf0});
    check({step, " overflow1"},  {1'b0, overflow1},  {1'b0, m_ovf1});
    check({step, " underflow0"}, {1'b0, underflow0}, {1'b0, m_unf0});
    check({step, " underflow1"}, {1'b0, underflow1}, {1'b0, m_unf1});
  endtask

  task automatic do_reset(input int unsigned cycles, input string step);
    reset = 1'b1; valid_in = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
    data_in = 2'b11; demux_sel = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    q0.delete(); q1.delete();
    m_data0 = '0; m_data1 = '0; m_valid0 = 1'b0; m_valid1 = 1'b0;
    m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_unf0 = 1'b0; m_unf1 = 1'b0;
    check_all(step);
    reset = 1'b0;
  endtask

  // One clock: predict both lanes (pop before push, so a full lane with pop accepts the push).
  task automatic cyc(input logic v, input logic [1:0] d, input logic sel,
                     input logic p0, input logic p1, input string step);
    logic pu0, pu1, ok0, ok1;
    valid_in = v; data_in = d; demux_sel = sel; pop0 = p0; pop1 = p1;
    pu0 = v & ~sel;
    pu1 = v & sel;
    ok0 = p0 && q0.size() > 0;
    ok1 = p1 && q1.size() > 0;
    m_valid0 = ok0;
    m_valid1 = ok1;
    if (ok0) m_data0 = q0.pop_front();
    else if (p0) m_unf0 = 1'b1;
    if (ok1) m_data1 = q1.pop_front();
    else if (p1) m_unf1 = 1'b1;
    if (pu0) begin
      if (q0.size() < 4) q0.push_back(d);
      else m_ovf0 = 1'b1;
    end
    if (pu1) begin
      if (q1.size() < 4) q1.push_back(d);
      else m_ovf1 = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(step);
  endtask

  initial begin
    // 1: reset held two cycles
    do_reset(2, "reset");

    // 2: three words through lane 0, junk on idle cycles ignored
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "l0 push01");
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "l0 push10");
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "l0 push11");
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, "idle junk");
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "l0 pop1");
    cyc(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, "l0 pop2");
    cyc(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, "l0 pop3");
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "l0 drained");

    // 3: five pushes into lane 1, fifth dropped, then drain four
    cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, "l1 push a");
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, "l1 push b");
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, "l1 push c");
    cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, "l1 push d");
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, "l1 push drop");
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "l1 drain");

    // 4: lane 0 full, simultaneous push and pop keeps it full without overflow
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "l0 fill a");
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "l0 fill b");
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "l0 fill c");
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "l0 fill d");
    cyc(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "l0 full push+pop");
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "l0 drain");

    // 5: underflow on empty lane 1; push+pop on empty lane stores the push
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "l1 underflow");
    cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, "l1 empty push+pop");
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "l1 pop stored");
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "l0 push");
    cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "both lanes");
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "l1 pop");

    // 6: partial fill of lane 0 then a one-cycle reset clears everything
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "pre-reset a");
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "pre-reset b");
    cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "pre-reset c");
    do_reset(1, "mid reset");
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "post-reset pop");
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, "post-reset push");
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "post-reset read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
